queue_ctrl: RTL

Pointer and status controller for the single-clock hardware queue. It accepts one-cycle push/pop requests and gates them into write/read enables. It maintains the write and read addresses for the queue storage RAM and publishes occupancy and full/empty/almost flags to the producer and consumer sides. It sits between the request sources and the dual-port queue memory and is the only block that decides whether a queue access happens.

---
 rtl/queue_ctrl_pkg.sv | 13 +
 rtl/queue_ptr.sv | 36 +++
 rtl/queue_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/queue_ctrl_pkg.sv
// queue_ctrl_pkg
//   Shared defaults for the queue pointer/status controller: the default
//   depth exponent and the default almost-full / almost-empty levels.
//   The optional sticky error flags are enabled by defining the macro
//   QUEUE_ERR_FLAG_EN at build time. It is left undefined by default.
//   This package has no ports.
package queue_ctrl_pkg;

  localparam int DEF_ADDR_W   = 4;   // depth = 2^DEF_ADDR_W = 16 entries
  localparam int DEF_AF_LEVEL = 14;  // almost_full when count >= this level
  localparam int DEF_AE_LEVEL = 2;   // almost_empty when count <= this level

endpackage

// File: rtl/queue_ptr.sv
// queue_ptr
//   W-bit wrapping pointer with an increment enable. The MSB acts as the wrap
//   bit when the pointer addresses a 2^(W-1)-entry queue.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (pointer -> 0)
//   inc    in   advance the pointer by one on this edge
//   ptr    out  W-bit pointer value (registered)
module queue_ptr
  import queue_ctrl_pkg::*;
#(
  parameter int W = DEF_ADDR_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // The natural modulo-2^W rollover carries the low bits into the wrap bit.
  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = ptr_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/queue_ctrl.sv
// queue_ctrl
//   Pointer and status controller for a single-clock queue. It gates one-cycle
//   push/pop requests into RAM write/read strobes, keeps the RAM addresses,
//   and publishes occupancy plus full/empty/almost flags.
//   Build option: QUEUE_ERR_FLAG_EN enables sticky overflow/underflow flags.
//   Without it both flags are tied to 0 and err_clr is ignored.
// Handshake: a request is accepted in the same cycle it is presented when the
//   queue can take it (push while not full, pop while not empty). An accepted
//   request produces wr_en/rd_en combinationally in that cycle, and the
//   pointer, count and flag updates appear after the next rising edge. A
//   rejected request is dropped. It is not held or retried.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   push, pop              write / read requests (one cycle per request)
//   err_clr                clears sticky error flags
//   wr_en, rd_en           RAM write / read strobes
//   wr_addr, rd_addr       RAM addresses (low ADDR_W bits of the pointers)
//   count                  occupancy 0..2^ADDR_W
//   full, empty            occupancy == depth / == 0
//   almost_full/_empty     count >= AF_LEVEL / count <= AE_LEVEL
//   overflow, underflow    sticky error flags
module queue_ctrl
  import queue_ctrl_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              err_clr,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] AF_L = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_L = AE_LEVEL[ADDR_W:0];

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] count_q;
  logic [ADDR_W:0] count_d;

  queue_ptr #(.W(ADDR_W + 1)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_en),
    .ptr   (wr_ptr)
  );

  queue_ptr #(.W(ADDR_W + 1)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_en),
    .ptr   (rd_ptr)
  );

  // Same low bits means the pointers address the same slot. The wrap bit
  // tells the queue apart as either empty or completely full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  assign wr_en = push & ~full;
  assign rd_en = pop  & ~empty;

  assign wr_addr = wr_ptr[ADDR_W-1:0];
  assign rd_addr = rd_ptr[ADDR_W-1:0];

  // A separate count register keeps the threshold compares off the pointer
  // subtractor. It tracks wr_ptr - rd_ptr exactly.
  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count        = count_q;
  assign almost_full  = (count_q >= AF_L);
  assign almost_empty = (count_q <= AE_L);

`ifdef QUEUE_ERR_FLAG_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  // A new error event wins over a clear in the same cycle.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (push && full)  overflow_d  = 1'b1;
    if (pop  && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule
